grapheme_job_injector: RTL

//  Head-of-chain source for the grapheme node ring.
//  - Accepts whole job buffers from the vcortex controller.
//  - Holds them in a 2-slot ping-pong store.
//  - Serialises each job onto the gnode_prot bus (SOP/VALID/EOP words) that drives ingr_* of the first grapheme_node_prot.
//  - Rejects jobs whose header destination is outside the node range, and keeps a sent-job count.

---
 rtl/grapheme_node_prot_pkg.sv | 35 +++
 rtl/grapheme_job_injector_if.sv | 24 ++
 rtl/grapheme_job_slot_buf.sv | 56 +++++
 rtl/grapheme_job_injector.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/grapheme_node_prot_pkg.sv
// Shared gnode_prot definitions: bus command encoding, job header layout,
// data widths and the injector send-FSM state type.
package grapheme_node_prot_pkg;

    localparam int DATA_W            = 32;
    localparam int GNODE_PROT_DATA_W = DATA_W;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_SOP   = 2'd1,
        CMD_VALID = 2'd2,
        CMD_EOP   = 2'd3
    } gnode_prot_cmd_t;

    // Header word layout; job_dst occupies the least significant byte.
    typedef struct packed {
        logic [15:0] job_len;
        logic [7:0]  job_src;
        logic [7:0]  job_dst;
    } gnode_prot_hdr_t;

    typedef enum logic {
        SEND_IDLE = 1'b0,
        SEND_PKT  = 1'b1
    } gnode_inj_state_t;

    // True when the header's destination names an existing ring node.
    function automatic logic dst_in_range(input logic [DATA_W-1:0] word,
                                          input int unsigned num_nodes);
        gnode_prot_hdr_t hdr;
        hdr = gnode_prot_hdr_t'(word);
        return 32'(hdr.job_dst) < num_nodes;
    endfunction

endpackage

// File: rtl/grapheme_job_injector_if.sv
// Host job handshake plus gnode_prot egress bus of the job injector.
// master = environment (controller + downstream node), slave = injector.
interface grapheme_job_injector_if
    import grapheme_node_prot_pkg::*;
#(
    parameter int BFFR_SIZE = 5
);
    logic                         host_job_valid;
    logic [DATA_W-1:0]            host_job_bffr [BFFR_SIZE];
    logic                         host_job_ready;
    gnode_prot_cmd_t              egr_cmd;
    logic [GNODE_PROT_DATA_W-1:0] egr_data;
    logic                         egr_ready;

    modport master (
        output host_job_valid, host_job_bffr, egr_ready,
        input  host_job_ready, egr_cmd, egr_data
    );

    modport slave (
        input  host_job_valid, host_job_bffr, egr_ready,
        output host_job_ready, egr_cmd, egr_data
    );
endinterface

// File: rtl/grapheme_job_slot_buf.sv
// Two-slot ping-pong job store. Owns the write/read slot pointers and the
// occupancy count; reads are combinational from slot (rd_ptr ^ rd_next_i).
module grapheme_job_slot_buf
    import grapheme_node_prot_pkg::*;
#(
    parameter int BFFR_SIZE = 5,
    parameter int IDX_W     = 3
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i [BFFR_SIZE],
    input  logic              pop_i,
    input  logic              rd_next_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o
);
    logic [DATA_W-1:0] mem_q [2][BFFR_SIZE];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;

    // Pointer and occupancy next-state; push and pop may coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push_i;
        rd_ptr_d = rd_ptr_q ^ pop_i;
        cnt_d    = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    // Pointer/occupancy registers; reset empties both slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Slot storage, written whole on push; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q ^ rd_next_i][rd_idx_i];
    assign full_o    = (cnt_q == 2'd2);
    assign empty_o   = (cnt_q == 2'd0);

endmodule

// File: rtl/grapheme_job_injector.sv
// Head-of-chain job injector: accepts whole job buffers, queues them in a
// two-slot store and serialises each onto the gnode_prot egress bus.
module grapheme_job_injector
    import grapheme_node_prot_pkg::*;
#(
    parameter string MODULE_NAME = "GRAPHEME_JOB_INJECTOR",
    parameter int    BFFR_SIZE   = 5,
    parameter int    NUM_NODES   = 4,
    parameter int    CNTR_W      = 16
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inj_en,
    grapheme_job_injector_if.slave  bus,
    output logic                    busy,
    output logic                    err_bad_dst,
    output logic [CNTR_W-1:0]       jobs_sent_cnt
);
    localparam int IDX_W = (BFFR_SIZE > 1) ? $clog2(BFFR_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BFFR_SIZE - 1);

    gnode_inj_state_t        state_q, state_d;
    logic [IDX_W-1:0]        word_idx_q, word_idx_d;
    gnode_prot_cmd_t         cmd_q, cmd_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [CNTR_W-1:0]       cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic                    accept, dst_ok, push, pop, beat;
    logic                    full, empty;
    logic                    rd_next;
    logic [IDX_W-1:0]        rd_idx, word_nxt;
    logic [DATA_W-1:0]       rd_word;

    grapheme_job_slot_buf #(
        .BFFR_SIZE (BFFR_SIZE),
        .IDX_W     (IDX_W)
    ) u_slot_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (bus.host_job_bffr),
        .pop_i       (pop),
        .rd_next_i   (rd_next),
        .rd_idx_i    (rd_idx),
        .rd_data_o   (rd_word),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign bus.host_job_ready = inj_en & ~full;
    assign accept   = bus.host_job_valid & bus.host_job_ready;
    assign dst_ok   = dst_in_range(bus.host_job_bffr[0], NUM_NODES);
    assign push     = accept & dst_ok;
    assign beat     = (cmd_q != CMD_IDLE) & bus.egr_ready;
    assign pop      = beat & (cmd_q == CMD_EOP);
    assign word_nxt = word_idx_q + IDX_W'(1);

    // Send FSM next-state and egress word selection.
    // With both slots empty the header is taken straight from the host bus so
    // SOP appears the cycle after accept; the slot is still written in parallel.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        rd_next    = 1'b0;
        rd_idx     = word_nxt;
        unique case (state_q)
            SEND_IDLE: begin
                rd_idx = '0;
                if (inj_en && !empty) begin
                    cmd_d      = CMD_SOP;
                    data_d     = rd_word;
                    word_idx_d = '0;
                    state_d    = SEND_PKT;
                end else if (push) begin
                    cmd_d      = CMD_SOP;
                    data_d     = bus.host_job_bffr[0];
                    word_idx_d = '0;
                    state_d    = SEND_PKT;
                end
            end
            SEND_PKT: begin
                if (beat) begin
                    if (cmd_q == CMD_EOP) begin
                        if (full && inj_en) begin
                            rd_next    = 1'b1;
                            rd_idx     = '0;
                            cmd_d      = CMD_SOP;
                            data_d     = rd_word;
                            word_idx_d = '0;
                        end else begin
                            cmd_d      = CMD_IDLE;
                            data_d     = '0;
                            word_idx_d = '0;
                            state_d    = SEND_IDLE;
                        end
                    end else begin
                        word_idx_d = word_nxt;
                        data_d     = rd_word;
                        cmd_d      = (word_nxt == LAST_IDX) ? CMD_EOP : CMD_VALID;
                    end
                end
            end
            default: state_d = SEND_IDLE;
        endcase
    end

    // Counter and bad-destination pulse next-state.
    always_comb begin
        cnt_d = cnt_q + {{(CNTR_W-1){1'b0}}, pop};
        err_d = accept & ~dst_ok;
    end

    // State, egress and status registers; reset abandons any partial packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEND_IDLE;
            word_idx_q <= '0;
            cmd_q      <= CMD_IDLE;
            data_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.egr_cmd  = cmd_q;
    assign bus.egr_data = data_q;
    assign busy         = ~empty | (state_q == SEND_PKT);
    assign err_bad_dst  = err_q;
    assign jobs_sent_cnt = cnt_q;

endmodule
